// File: rtl/sd_pkg.sv
// Shared constants and drain-state type for the SD single-block write path.
package sd_pkg;

  localparam int unsigned SD_SEC_WORDS = 256;
  localparam logic [15:0] SD_PAD_WORD  = 16'hFFFF;

  typedef enum logic [2:0] {
    D_IDLE,
    D_START,
    D_STREAM,
    D_WAIT,
    D_DONE
  } sd_wr_buf_state_t;

endpackage

// File: rtl/sd_wr_bank_ram.sv
// 512x16 simple dual-port RAM (two 256-word sector banks) with registered read port.
module sd_wr_bank_ram (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        we,
  input  logic [8:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        re,
  input  logic [8:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [0:511];

  always_ff @(posedge clk_ref) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_wr_buf.sv
// Ping-pong sector staging buffer in front of the SD single-block write engine.
// Optional partial-sector flush with pad fill is built when SD_WR_BUF_FLUSH_EN is defined.
module sd_wr_buf
  import sd_pkg::*;
#(
  parameter int unsigned SEC_WORDS = SD_SEC_WORDS,
  parameter logic [15:0] PAD_WORD  = SD_PAD_WORD
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sec_base,
  input  logic        sec_load,
  input  logic        flush,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  input  logic        wr_req,
  input  logic        wr_busy,
  output logic [15:0] sec_cnt,
  output logic        err
);

  localparam logic [7:0] LAST_IDX = 8'(SEC_WORDS - 1);

  sd_wr_buf_state_t state;
  logic [1:0]  bank_full;
  logic        fill_bank;
  logic [7:0]  fill_idx;
  logic        drain_bank;
  logic [7:0]  rd_idx;
  logic [31:0] next_addr;
  logic        reload_pend;
  logic        busy_q;
  logic [1:0]  hold_cnt;
  logic        padding;
  logic        accept;
  logic        we;
  logic        fill_last;
  logic        release_bank;
  logic        rd_en;
  logic [15:0] wdata;

  assign in_ready     = !bank_full[fill_bank] && !padding;
  assign accept       = in_valid && in_ready;
  assign we           = accept || padding;
  assign wdata        = padding ? PAD_WORD : in_data;
  assign fill_last    = we && (fill_idx == LAST_IDX);
  assign release_bank = (state == D_DONE);
  assign rd_en        = wr_req && (state == D_STREAM);

`ifdef SD_WR_BUF_FLUSH_EN
  // Padding is skipped when the flush coincides with the word that fills the bank.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      padding <= 1'b0;
    end else if (padding) begin
      if (fill_idx == LAST_IDX) padding <= 1'b0;
    end else if (flush && (fill_idx != '0) && !(accept && (fill_idx == LAST_IDX))) begin
      padding <= 1'b1;
    end
  end
`else
  logic unused_flush;
  assign padding      = 1'b0;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank <= 1'b0;
      fill_idx  <= '0;
      bank_full <= '0;
    end else begin
      if (release_bank) bank_full[drain_bank] <= 1'b0;
      if (fill_last)    bank_full[fill_bank]  <= 1'b1;
      if (we) begin
        fill_idx <= fill_idx + 8'd1;
        if (fill_last) fill_bank <= ~fill_bank;
      end
    end
  end

  // A sec_load seen since the last launch suppresses the post-sector increment,
  // so the loaded base is used verbatim by the next write.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state       <= D_IDLE;
      drain_bank  <= 1'b0;
      rd_idx      <= '0;
      next_addr   <= '0;
      reload_pend <= 1'b0;
      busy_q      <= 1'b0;
      hold_cnt    <= '0;
      wr_start_en <= 1'b0;
      wr_sec_addr <= '0;
      sec_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      busy_q <= wr_busy;
      if (wr_req && (state != D_STREAM)) err <= 1'b1;
      case (state)
        D_IDLE: begin
          if (bank_full[drain_bank] && !wr_busy) begin
            wr_sec_addr <= next_addr;
            reload_pend <= 1'b0;
            state       <= D_START;
          end
        end
        D_START: begin
          if (!wr_start_en) begin
            wr_start_en <= 1'b1;
            hold_cnt    <= '0;
          end else if (hold_cnt != 2'd2) begin
            hold_cnt <= hold_cnt + 2'd1;
          end else if (wr_busy) begin
            wr_start_en <= 1'b0;
            rd_idx      <= '0;
            state       <= D_STREAM;
          end
        end
        D_STREAM: begin
          if (wr_req) rd_idx <= rd_idx + 8'd1;
          if (busy_q && !wr_busy) begin
            err   <= 1'b1;
            state <= D_WAIT;
          end else if (wr_req && (rd_idx == LAST_IDX)) begin
            state <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (!wr_busy) state <= D_DONE;
        end
        D_DONE: begin
          drain_bank  <= ~drain_bank;
          sec_cnt     <= sec_cnt + 16'd1;
          reload_pend <= 1'b0;
          if (!reload_pend) next_addr <= next_addr + 32'd1;
          state <= D_IDLE;
        end
        default: state <= D_IDLE;
      endcase
      if (sec_load) begin
        next_addr   <= sec_base;
        reload_pend <= 1'b1;
      end
    end
  end

  sd_wr_bank_ram u_ram (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   ({fill_bank, fill_idx}),
    .wdata   (wdata),
    .re      (rd_en),
    .raddr   ({drain_bank, rd_idx}),
    .rdata   (wr_data)
  );

endmodule

// File: tb/tb_sd_wr_buf.sv
// Directed/randomized bench for sd_wr_buf using a FIFO-of-words model and a behavioural engine.
// Honors SD_WR_BUF_FLUSH_EN to select the flush expectations.
module tb_sd_wr_buf;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sec_base;
  logic        sec_load;
  logic        flush;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        wr_req;
  logic        wr_busy;
  logic [15:0] sec_cnt;
  logic        err;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [15:0] model_q [$];

  always #5 clk_ref = ~clk_ref;

  sd_wr_buf dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sec_base    (sec_base),
    .sec_load    (sec_load),
    .flush       (flush),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .wr_data     (wr_data),
    .wr_req      (wr_req),
    .wr_busy     (wr_busy),
    .sec_cnt     (sec_cnt),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_start_en", 32'(wr_start_en), 32'd0);
    check("rst_wr_sec_addr", wr_sec_addr, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_sec_cnt", 32'(sec_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic push_word(input logic [15:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10000) begin
      @(negedge clk_ref);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    model_q.push_back(w);
    @(negedge clk_ref);
    in_valid = 1'b0;
  endtask

  task automatic push_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) push_word(seq ? 16'(i) : 16'($urandom));
  endtask

  task automatic pulse_load(input logic [31:0] base);
    sec_base = base;
    sec_load = 1'b1;
    @(negedge clk_ref);
    sec_load = 1'b0;
  endtask

  // Behavioural engine: answers one start, pulls stop_at words, then releases busy.
  task automatic engine_sector(input logic [31:0] exp_addr, input int gap_max,
                               input int reload_at, input int stop_at);
    int          n;
    logic [15:0] w;
    n = 0;
    while (!wr_start_en && n < 10000) begin
      @(negedge clk_ref);
      n++;
    end
    check("start_seen", 32'(wr_start_en), 32'd1);
    if (!wr_start_en) return;
    check("wr_sec_addr", wr_sec_addr, exp_addr);
    wr_busy = 1'b1;
    n = 0;
    while (wr_start_en && n < 20) begin
      @(negedge clk_ref);
      n++;
    end
    check("start_drop", 32'(wr_start_en), 32'd0);
    if (wr_start_en) return;
    for (int i = 0; i < stop_at; i++) begin
      wr_req = 1'b1;
      if (i == reload_at) begin
        sec_base = 32'h0000_2000;
        sec_load = 1'b1;
      end
      @(negedge clk_ref);
      wr_req   = 1'b0;
      sec_load = 1'b0;
      @(negedge clk_ref);
      check("model_nonempty", 32'(model_q.size() > 0), 32'd1);
      w = 16'h0;
      if (model_q.size() > 0) w = model_q.pop_front();
      check("wr_data", 32'(wr_data), 32'(w));
      repeat ($urandom_range(0, gap_max)) @(negedge clk_ref);
    end
    if (stop_at < 256) return;
    repeat (2) @(negedge clk_ref);
    wr_busy = 1'b0;
    repeat (3) @(negedge clk_ref);
    exp_cnt++;
  endtask

  initial begin
    logic [31:0] pre_rst_addr;
    int          saw_start;
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    sec_base = '0;
    sec_load = 1'b0;
    flush    = 1'b0;
    wr_req   = 1'b0;
    wr_busy  = 1'b0;
    repeat (3) @(negedge clk_ref);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk_ref);

    // Single sector with a sequential ramp, plus launch latency.
    pulse_load(32'h0000_1000);
    push_words(256, 1'b1);
    check("start_lat0", 32'(wr_start_en), 32'd0);
    repeat (2) @(negedge clk_ref);
    check("start_lat2", 32'(wr_start_en), 32'd1);
    engine_sector(32'h0000_1000, 0, -1, 256);
    check("sec_cnt_single", 32'(sec_cnt), 32'(exp_cnt));
    check("err_single", 32'(err), 32'd0);

    // Back-pressure: both banks full while the engine ignores the start.
    pulse_load(32'h0000_1000);
    push_words(512, 1'b0);
    check("both_full_ready", 32'(in_ready), 32'd0);
    check("both_full_start", 32'(wr_start_en), 32'd1);
    fork
      begin
        engine_sector(32'h0000_1000, 3, -1, 256);
        engine_sector(32'h0000_1001, 3, -1, 256);
        engine_sector(32'h0000_1002, 3, -1, 256);
      end
      push_words(256, 1'b0);
    join
    check("sec_cnt_bp", 32'(sec_cnt), 32'(exp_cnt));
    check("model_drained_bp", 32'(model_q.size()), 32'd0);

    // Reload during streaming affects only the following sector.
    pulse_load(32'h0000_3000);
    fork
      engine_sector(32'h0000_3000, 1, 100, 256);
      push_words(256, 1'b0);
    join
    fork
      engine_sector(32'h0000_2000, 1, -1, 256);
      push_words(256, 1'b0);
    join
    check("sec_cnt_reload", 32'(sec_cnt), 32'(exp_cnt));
    check("err_before_stray", 32'(err), 32'd0);

    // Stray request while idle sets a sticky error; traffic still completes.
    wr_req = 1'b1;
    @(negedge clk_ref);
    wr_req = 1'b0;
    @(negedge clk_ref);
    check("err_stray", 32'(err), 32'd1);
    fork
      engine_sector(32'h0000_2001, 2, -1, 256);
      push_words(256, 1'b0);
    join
    check("err_sticky", 32'(err), 32'd1);
    check("sec_cnt_stray", 32'(sec_cnt), 32'(exp_cnt));

    // Partial bank followed by flush.
    push_words(10, 1'b0);
    flush = 1'b1;
    @(negedge clk_ref);
    flush = 1'b0;
`ifdef SD_WR_BUF_FLUSH_EN
    for (int i = 0; i < 246; i++) model_q.push_back(16'hFFFF);
    engine_sector(32'h0000_2002, 0, -1, 256);
    check("sec_cnt_flush", 32'(sec_cnt), 32'(exp_cnt));
    pre_rst_addr = 32'h0000_2003;
`else
    saw_start = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_ref);
      if (wr_start_en) saw_start = 1;
    end
    check("flush_ignored", 32'(saw_start), 32'd0);
    pre_rst_addr = 32'h0000_2002;
`endif

    // Reset in the middle of streaming, then a clean sector from address 0.
    fork
      engine_sector(pre_rst_addr, 0, -1, 50);
      push_words(256, 1'b0);
    join
    rst_n   = 1'b0;
    wr_busy = 1'b0;
    #1;
    check_reset_vals();
    model_q.delete();
    exp_cnt = 0;
    @(negedge clk_ref);
    rst_n = 1'b1;
    @(negedge clk_ref);
    fork
      engine_sector(32'h0000_0000, 1, -1, 256);
      push_words(256, 1'b0);
    join
    check("sec_cnt_post_rst", 32'(sec_cnt), 32'(exp_cnt));
    check("err_post_rst", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_wr_buf.md
# sd_wr_buf

Sector-staging ping-pong buffer sitting directly upstream of the SD single-block write engine. It accepts a 16-bit word stream from a producer with a valid/ready handshake and packs 256 words (one 512-byte sector) into one of two banks. For each full bank it launches a write via `wr_start_en`/`wr_sec_addr`, serves words on each `wr_req` pulse, and advances the sector address when the engine's `wr_busy` falls.

## Interface
- `SEC_WORDS`, 256: words per sector; the design relies on this value being fixed.
- `PAD_WORD`, 16'hFFFF: fill value for the unfilled part of a flushed bank.
- `clk_ref`  in  1  clock, shared with the write engine.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  16  producer word.
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  a buffer slot is free; a word transfers when `in_valid & in_ready`.
- `sec_base`  in  32  sector address to load.
- `sec_load`  in  1  pulse; loads `sec_base` into the next-sector address register.
- `flush`  in  1  pulse; commits a partially filled bank (`SD_WR_BUF_FLUSH_EN` only).
- `wr_start_en`  out  1  write request level to the engine.
- `wr_sec_addr`  out  32  sector address for the current write.
- `wr_data`  out  16  word for the engine.
- `wr_req`  in  1  engine word request pulse.
- `wr_busy`  in  1  engine busy.
- `sec_cnt`  out  16  sectors completed, wraps modulo 2^16.
- `err`  out  1  sticky flag for a protocol violation.

## Operation
- **Fill side.**
  - Write pointer `fill_bank` (1 bit) and word index `fill_idx` (8 bits).
  - `in_ready` = bank[`fill_bank`] not full.
  - Each accepted word is written at [`fill_bank`][`fill_idx`] and `fill_idx` increments.
  - When index 255 is written, the bank is marked full, `fill_bank` toggles and `fill_idx` returns to 0.
- **Drain FSM states:** D_IDLE, D_START, D_STREAM, D_WAIT, D_DONE.
  - D_IDLE: if bank[`drain_bank`] is full and `wr_busy`=0, latch `wr_sec_addr` from `next_addr` and go to D_START.
  - D_START: hold `wr_start_en`=1 until `wr_busy`=1, then drop `wr_start_en` and go to D_STREAM with `rd_idx`=0.
  - D_STREAM: each `wr_req` pulse triggers a read at [`drain_bank`][`rd_idx`] and increments `rd_idx`. After the 256th request, go to D_WAIT.
  - D_WAIT: when `wr_busy`=0, go to D_DONE.
  - D_DONE: clear the bank's full flag, toggle `drain_bank`, set `next_addr` += 1, set `sec_cnt` += 1, go to D_IDLE.
- `sec_load` writes `next_addr` in any state. It only affects writes launched afterwards, because `wr_sec_addr` stays frozen from D_START through D_DONE.
- `err` sets on any of:
  - a `wr_req` pulse outside D_STREAM;
  - `wr_busy` falling while in D_STREAM.
  
  In either case the FSM still proceeds through D_WAIT/D_DONE and releases the bank. `err` clears only on reset.
- Boundary conditions:
  - Bank fill and bank release in the same cycle: both take effect.
  - Both banks full: `in_ready`=0.
  - Reset mid-sector: all flags, pointers and counters clear, and bank contents are discarded.

## Timing
- Reset values:
  - `in_ready`=1, `wr_start_en`=0, `wr_sec_addr`=0, `wr_data`=0, `sec_cnt`=0, `err`=0.
  - `next_addr`=0, FSM in D_IDLE.
- `wr_data` is registered and valid 1 cycle after a `wr_req` pulse, then holds until the next read. The engine samples it 2 cycles after the request.
- `wr_start_en` rises 1 cycle after entering D_START and stays high for at least 3 cycles, which covers the engine's 2-flop edge detector.
- Words accepted into a bank are visible to the drain side no earlier than the cycle after the full flag sets.
- Minimum time from the 256th `in_data` word to `wr_start_en` high: 2 cycles.

## Configuration
- `SD_WR_BUF_FLUSH_EN` defined:
  - A `flush` pulse with `fill_idx`≠0 writes `PAD_WORD` into the remaining slots, one per cycle, with `in_ready`=0 during padding.
  - The bank is then marked full.
  - `flush` with `fill_idx`=0 does nothing.
- `SD_WR_BUF_FLUSH_EN` undefined: `flush` is ignored, no pad logic is built, and a partial bank waits for more words.

## Structure
- Shared package `sd_pkg`: `SD_SEC_WORDS`=256, drain-state typedef `sd_wr_buf_state_t`, `SD_PAD_WORD` constant.
- Sub-module `sd_wr_bank_ram`: 512×16 simple dual-port RAM with synchronous read.
  - Write address {`fill_bank`, `fill_idx`}.
  - Read address {`drain_bank`, `rd_idx`}.

## Test plan
- **Single sector:** `sec_load` with 0x0000_1000, then 256 words 0..255 → one `wr_start_en` with `wr_sec_addr`=0x1000; `wr_data` sequence 0..255 on successive `wr_req`; `sec_cnt`=1.
- **Back-pressure:** 768 words streamed with a slow engine model → `in_ready` low while both banks are full, no word lost, addresses 0x1000/0x1001/0x1002 in order.
- **Flush (macro on):** 10 words then `flush` → the sector carries the 10 words followed by 246×0xFFFF. **Macro off:** the same stimulus produces no `wr_start_en`.
- **Reload mid-write:** `sec_load` with 0x2000 during D_STREAM → the current sector keeps its address and the next sector uses 0x2000.
- **Stray `wr_req`:** one pulse while in D_IDLE → `err`=1 and stays 1; subsequent sectors still complete.
- **Reset during D_STREAM:** reset asserted → all outputs return to reset values and `in_ready`=1 within the reset cycle.
